// File: rtl/fb_arb_pkg.sv
// fb_arb_pkg: state encoding, default widths and grant helper shared by the frame-buffer port arbiter
package fb_arb_pkg;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 24;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      RELEASE = 2'd2,
      DONE    = 2'd3
   } state_t;

   function automatic logic [1:0] onehot(input logic g);
      return g ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/fb_port_arbiter_if.sv
// fb_port_arbiter_if: frame-buffer pixel port bundle (4-phase request/ready, asynchronous ready)
interface fb_port_arbiter_if
   import fb_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);

   logic              px_request;
   logic              px_write;
   logic [ADDR_W-1:0] px_address;
   logic [DATA_W-1:0] px_write_data;
   logic              px_ready_a;
   logic [DATA_W-1:0] px_read_data;

   modport master (
      output px_request, px_write, px_address, px_write_data,
      input  px_ready_a, px_read_data
   );

   modport slave (
      input  px_request, px_write, px_address, px_write_data,
      output px_ready_a, px_read_data
   );

endinterface

// File: rtl/fb_ready_sync.sv
// fb_ready_sync: SYNC_STAGES-deep flop chain bringing an asynchronous ready into the clk domain
module fb_ready_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_a,
   output logic q
);

   logic [SYNC_STAGES-1:0] sr;

   // shift the asynchronous level through the chain; cleared with the block reset
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sr <= '0;
      else sr <= {sr[SYNC_STAGES-2:0], d_a};

   assign q = sr[SYNC_STAGES-1];

endmodule

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: round-robin sharing of the frame-buffer pixel port between two 4-phase requesters (watchdog under FB_ARB_TIMEOUT_EN)
module fb_port_arbiter
   import fb_arb_pkg::*;
#(
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int DATA_W         = DEF_DATA_W,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          rq_req,
   input  logic [1:0]          rq_write,
   input  logic [2*ADDR_W-1:0] rq_addr,
   input  logic [2*DATA_W-1:0] rq_wdata,
   output logic [1:0]          rq_ready,
   output logic [DATA_W-1:0]   rq_rdata,
   fb_port_arbiter_if.master   px,
   output logic [1:0]          grant,
   output logic                busy,
   output logic                err_timeout
);

   state_t            state, state_n;
   logic              rdy_s, last_grant, last_n, g, gi, tmo, err_n;
   logic              req_n, wr_n;
   logic [ADDR_W-1:0] addr_n, addr_g;
   logic [DATA_W-1:0] wdata_n, wdata_g, rdata_n;
   logic [1:0]        grant_n, ready_n;

   fb_ready_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_a   (px.px_ready_a),
      .q     (rdy_s)
   );

   assign g       = (&rq_req) ? ~last_grant : rq_req[1];
   assign gi      = grant[1];
   assign addr_g  = g ? rq_addr[2*ADDR_W-1:ADDR_W] : rq_addr[ADDR_W-1:0];
   assign wdata_g = g ? rq_wdata[2*DATA_W-1:DATA_W] : rq_wdata[DATA_W-1:0];
   assign busy    = state != IDLE;

`ifdef FB_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt;

   // watchdog: counts cycles spent waiting on the frame buffer, restarting on every state change
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else cnt <= (state_n != state || state == IDLE || state == DONE) ? '0 : cnt + 1'b1;

   assign tmo = (state == REQ || state == RELEASE) && cnt == CNT_W'(TIMEOUT_CYCLES - 1);
`else
   assign tmo = 1'b0;
`endif

   // next-state and registered-output values; a watchdog expiry overrides the normal flow
   always_comb begin
      state_n = state;
      req_n   = px.px_request;
      wr_n    = px.px_write;
      addr_n  = px.px_address;
      wdata_n = px.px_write_data;
      grant_n = grant;
      ready_n = rq_ready;
      rdata_n = rq_rdata;
      last_n  = last_grant;
      err_n   = err_timeout | tmo;
      if (tmo) begin
         state_n = DONE;
         req_n   = 1'b0;
         rdata_n = '0;
         ready_n = onehot(gi);
      end else begin
         case (state)
            IDLE: if (|rq_req && !rdy_s) begin
               state_n = REQ;
               req_n   = 1'b1;
               wr_n    = rq_write[g];
               addr_n  = addr_g;
               wdata_n = wdata_g;
               grant_n = onehot(g);
            end
            REQ: if (rdy_s) begin
               state_n = RELEASE;
               req_n   = 1'b0;
               rdata_n = px.px_write ? rq_rdata : px.px_read_data;
            end
            RELEASE: if (!rdy_s) begin
               state_n = rq_req[gi] ? DONE : IDLE;
               ready_n = rq_req[gi] ? grant : 2'b00;
               grant_n = rq_req[gi] ? grant : 2'b00;
               last_n  = rq_req[gi] ? last_grant : gi;
            end
            DONE: if (!rq_req[gi]) begin
               state_n = IDLE;
               ready_n = 2'b00;
               grant_n = 2'b00;
               last_n  = gi;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // state and output registers; reset aborts any transaction and hands port 0 the first grant
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state            <= IDLE;
         px.px_request    <= 1'b0;
         px.px_write      <= 1'b0;
         px.px_address    <= '0;
         px.px_write_data <= '0;
         grant            <= 2'b00;
         rq_ready         <= 2'b00;
         rq_rdata         <= '0;
         last_grant       <= 1'b1;
         err_timeout      <= 1'b0;
      end else begin
         state            <= state_n;
         px.px_request    <= req_n;
         px.px_write      <= wr_n;
         px.px_address    <= addr_n;
         px.px_write_data <= wdata_n;
         grant            <= grant_n;
         rq_ready         <= ready_n;
         rq_rdata         <= rdata_n;
         last_grant       <= last_n;
         err_timeout      <= err_n;
      end

endmodule
